// File: rtl/nios_mul_pkg.sv
// Shared definitions for the NIOS multiplier: op encodings and operand signedness per op.
// Latency: n/a (package).
// Backpressure: n/a (package).
package nios_mul_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MUL    = 2'b00;
  localparam op_t OP_MULXSS = 2'b01;
  localparam op_t OP_MULXSU = 2'b10;
  localparam op_t OP_MULXUU = 2'b11;

  // Operand A is treated as signed for MULXSS and MULXSU.
  function automatic logic op_signed_a(input op_t op);
    return (op == OP_MULXSS) || (op == OP_MULXSU);
  endfunction

  // Operand B is treated as signed only for MULXSS.
  function automatic logic op_signed_b(input op_t op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/nios_mul_unit_pp_cell.sv
// One registered unsigned HALF_W x HALF_W partial-product multiplier (maps to a DSP block).
// Latency: 1 cycle from en to p.
// Backpressure: none; p holds whenever en is low.
// Ports: clk, reset (async active-high), en (load strobe), a/b (HALF_W operands), p (2*HALF_W product).
module nios_mul_unit_pp_cell #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/nios_mul_unit.sv
// Pipelined integer multiplier: half-word partial products, signed correction, low/high word select.
// Latency: PIPE_STAGES cycles from accept to out_valid; one op per cycle.
// Backpressure: out_valid && !out_ready stalls the whole pipe and drops in_ready; flush kills all in-flight ops.
// Ports: clk, reset (async active-high), flush; in_valid/in_ready/in_op/in_src1/in_src2/in_tag;
//        out_valid/out_ready/out_result/out_tag/out_err; busy.
// Build option: NIOS_MUL_UNIT_HI_EN enables the high-word ops (MULXSS/MULXSU/MULXUU).
module nios_mul_unit
  import nios_mul_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  // Register stages after the partial-product stage; the last one drives the outputs.
  localparam int NS     = PIPE_STAGES - 1;

  // ------------------------------------------------------------------
  // Flow control
  // ------------------------------------------------------------------
  logic stall;
  logic adv;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !flush;
  assign accept   = in_valid && in_ready;
  // Data registers only move on a real advance; a flush cycle leaves them alone.
  assign adv      = !stall && !flush;

  // ------------------------------------------------------------------
  // Stage 1: partial products plus control
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] p_ll;
  logic [DATA_W-1:0] p_lh;
  logic [DATA_W-1:0] p_hl;

  nios_mul_unit_pp_cell #(.HALF_W(HALF_W)) u_pp_ll (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[HALF_W-1:0]), .p(p_ll)
  );

  nios_mul_unit_pp_cell #(.HALF_W(HALF_W)) u_pp_lh (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[DATA_W-1:HALF_W]), .p(p_lh)
  );

  nios_mul_unit_pp_cell #(.HALF_W(HALF_W)) u_pp_hl (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[HALF_W-1:0]), .p(p_hl)
  );

  logic             s1_vld;
  op_t              s1_op;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_op  <= OP_MUL;
      s1_tag <= '0;
    end else begin
      if (flush) begin
        s1_vld <= 1'b0;
      end else if (!stall) begin
        s1_vld <= accept;
      end
      if (accept) begin
        s1_op  <= op_t'(in_op);
        s1_tag <= in_tag;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: sum, signed correction, word select
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] s2_res;
  logic              s2_err;

`ifdef NIOS_MUL_UNIT_HI_EN
  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] p_hh;
  logic [DATA_W-1:0] corr_in;
  logic [DATA_W-1:0] s1_corr;
  logic [PW-1:0]     u_sum;
  logic [DATA_W-1:0] p_hi;

  nios_mul_unit_pp_cell #(.HALF_W(HALF_W)) u_pp_hh (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[DATA_W-1:HALF_W]), .p(p_hh)
  );

  // The signed correction only touches the high word, so fold both terms
  // into one DATA_W-bit subtrahend while the operands are still at hand.
  always_comb begin
    corr_in = '0;
    if (op_signed_a(op_t'(in_op)) && in_src1[DATA_W-1]) begin
      corr_in = corr_in + in_src2;
    end
    if (op_signed_b(op_t'(in_op)) && in_src2[DATA_W-1]) begin
      corr_in = corr_in + in_src1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_corr <= '0;
    end else if (accept) begin
      s1_corr <= corr_in;
    end
  end

  always_comb begin
    u_sum  = PW'(p_ll)
           + (PW'(p_lh) << HALF_W)
           + (PW'(p_hl) << HALF_W)
           + (PW'(p_hh) << DATA_W);
    p_hi   = u_sum[PW-1:DATA_W] - s1_corr;
    s2_res = (s1_op == OP_MUL) ? u_sum[DATA_W-1:0] : p_hi;
    s2_err = 1'b0;
  end
`else
  logic [DATA_W-1:0] mid_sum;
  logic [DATA_W-1:0] low_sum;

  // Only the low word is built; carries out of it are deliberately dropped.
  always_comb begin
    mid_sum = p_lh + p_hl;
    low_sum = p_ll + (mid_sum << HALF_W);
    s2_res  = (s1_op == OP_MUL) ? low_sum : '0;
    s2_err  = (s1_op != OP_MUL);
  end
`endif

  // ------------------------------------------------------------------
  // Result stages: index 0 is the stage-2 register, NS-1 drives the outputs
  // ------------------------------------------------------------------
  logic [NS-1:0]             st_vld;
  logic [NS-1:0][DATA_W-1:0] st_res;
  logic [NS-1:0][TAG_W-1:0]  st_tag;
  logic [NS-1:0]             st_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_vld <= '0;
      st_res <= '0;
      st_tag <= '0;
      st_err <= '0;
    end else begin
      if (flush) begin
        st_vld <= '0;
      end else if (!stall) begin
        st_vld[0] <= s1_vld;
        for (int i = 1; i < NS; i++) begin
          st_vld[i] <= st_vld[i-1];
        end
      end
      // Payload only follows a valid op, so idle stages never overwrite a result.
      if (adv) begin
        if (s1_vld) begin
          st_res[0] <= s2_res;
          st_tag[0] <= s1_tag;
          st_err[0] <= s2_err;
        end
        for (int i = 1; i < NS; i++) begin
          if (st_vld[i-1]) begin
            st_res[i] <= st_res[i-1];
            st_tag[i] <= st_tag[i-1];
            st_err[i] <= st_err[i-1];
          end
        end
      end
    end
  end

  assign out_valid  = st_vld[NS-1];
  assign out_result = st_res[NS-1];
  assign out_tag    = st_tag[NS-1];
  assign out_err    = st_err[NS-1];
  assign busy       = s1_vld || (|st_vld);

endmodule
